// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - playback controller driving song_reader play, song select and restart
module song_sequencer #(
    parameter int SONG_W     = 2,
    parameter int NUM_SONGS  = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_button,
    input  logic              stop_button,
    input  logic              next_button,
    input  logic              prev_button,
    input  logic [1:0]        mode,
    input  logic              song_done,
    output logic              play,
    output logic              reset_player,
    output logic [SONG_W-1:0] song,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_PLAYING = 3'd2,
        S_PAUSED  = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
    localparam logic [15:0]       GAP_LOAD  = 16'(GAP_CYCLES - 1);

    state_t            state_q, state_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic              resume_q, resume_d;
    logic [15:0]       gap_q, gap_d;
    logic [SONG_W-1:0] song_inc, song_dec;
    logic              advance;

    assign song_inc = (song_q == LAST_SONG) ? '0 : song_q + 1'b1;
    assign song_dec = (song_q == '0) ? LAST_SONG : song_q - 1'b1;

    always_comb begin
        state_d  = state_q;
        song_d   = song_q;
        resume_d = resume_q;
        gap_d    = gap_q;
        advance  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // song_done is masked here, so it does not shadow the buttons
                if (stop_button) begin
                    state_d  = S_LOAD;
                    resume_d = 1'b0;
                end else if (next_button) begin
                    song_d   = song_inc;
                    state_d  = S_LOAD;
                    resume_d = 1'b0;
                end else if (prev_button) begin
                    song_d   = song_dec;
                    state_d  = S_LOAD;
                    resume_d = 1'b0;
                end else if (play_button) begin
                    state_d  = S_LOAD;
                    resume_d = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = resume_q ? S_PLAYING : S_IDLE;
            end
            S_PLAYING: begin
                if (stop_button) begin
                    state_d  = S_LOAD;
                    resume_d = 1'b0;
                end else if (song_done) begin
                    case (mode)
                        2'b00: begin
                            state_d  = S_LOAD;
                            resume_d = 1'b0;
                        end
                        2'b01: begin
                            if (song_q != LAST_SONG) begin
                                song_d  = song_inc;
                                advance = 1'b1;
                            end else begin
                                state_d  = S_LOAD;
                                resume_d = 1'b0;
                            end
                        end
                        2'b10: begin
                            song_d  = song_inc;
                            advance = 1'b1;
                        end
                        default: advance = 1'b1;
                    endcase
                end else if (next_button) begin
                    song_d   = song_inc;
                    state_d  = S_LOAD;
                    resume_d = 1'b1;
                end else if (prev_button) begin
                    song_d   = song_dec;
                    state_d  = S_LOAD;
                    resume_d = 1'b1;
                end else if (play_button) begin
                    state_d = S_PAUSED;
                end
                // Automatic advance either waits out the silent gap or restarts at once
                if (advance) begin
                    if (GAP_CYCLES == 0) begin
                        state_d  = S_LOAD;
                        resume_d = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            S_PAUSED: begin
                if (stop_button) begin
                    state_d  = S_LOAD;
                    resume_d = 1'b0;
                end else if (next_button) begin
                    song_d   = song_inc;
                    state_d  = S_LOAD;
                    resume_d = 1'b0;
                end else if (prev_button) begin
                    song_d   = song_dec;
                    state_d  = S_LOAD;
                    resume_d = 1'b0;
                end else if (play_button) begin
                    state_d = S_PLAYING;
                end
            end
            S_GAP: begin
                if (stop_button) begin
                    state_d  = S_LOAD;
                    resume_d = 1'b0;
                end else if (gap_q == 16'd0) begin
                    state_d  = S_LOAD;
                    resume_d = 1'b1;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            song_q       <= '0;
            resume_q     <= 1'b0;
            gap_q        <= 16'd0;
            play         <= 1'b0;
            reset_player <= 1'b0;
        end else begin
            state_q      <= state_d;
            song_q       <= song_d;
            resume_q     <= resume_d;
            gap_q        <= gap_d;
            play         <= (state_d == S_PLAYING);
            reset_player <= (state_d == S_LOAD);
        end
    end

    assign song  = song_q;
    assign state = state_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - scoreboard bench for song_sequencer against a behavioural playback model
module tb_song_sequencer;

    localparam int SONG_W     = 2;
    localparam int NUM_SONGS  = 4;
    localparam int GAP_CYCLES = 8;

    localparam int IDLE = 0, LOAD = 1, PLAYING = 2, PAUSED = 3, GAP = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              play_button = 1'b0;
    logic              stop_button = 1'b0;
    logic              next_button = 1'b0;
    logic              prev_button = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              song_done = 1'b0;
    logic              play;
    logic              reset_player;
    logic [SONG_W-1:0] song;
    logic [2:0]        state;

    song_sequencer #(
        .SONG_W(SONG_W), .NUM_SONGS(NUM_SONGS), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .play_button(play_button), .stop_button(stop_button),
        .next_button(next_button), .prev_button(prev_button),
        .mode(mode), .song_done(song_done),
        .play(play), .reset_player(reset_player), .song(song), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int sg;
        bit pl;
        bit rp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cur_mode = 0;
    int   cycle_no = 0;

    // Reference model: phase, current track, whether LOAD ends in playback, gap cycles still to sit out
    int m_phase, m_track, m_gap_left;
    bit m_resume;

    function automatic int next_track(int t);
        return (t + 1) % NUM_SONGS;
    endfunction

    function automatic int prev_track(int t);
        return (t + NUM_SONGS - 1) % NUM_SONGS;
    endfunction

    function void model_reset();
        m_phase = IDLE; m_track = 0; m_resume = 0; m_gap_left = 0;
    endfunction

    function void go_load(bit res);
        m_phase = LOAD; m_resume = res;
    endfunction

    function void start_next_song(int t);
        m_track = t;
        if (GAP_CYCLES == 0) go_load(1);
        else begin
            m_phase = GAP; m_gap_left = GAP_CYCLES;
        end
    endfunction

    function void model_step(bit p, bit s, bit n, bit v, bit d, int md);
        case (m_phase)
            IDLE: begin
                if (s) go_load(0);
                else if (n) begin m_track = next_track(m_track); go_load(0); end
                else if (v) begin m_track = prev_track(m_track); go_load(0); end
                else if (p) go_load(1);
            end
            LOAD: m_phase = m_resume ? PLAYING : IDLE;
            PLAYING: begin
                if (s) go_load(0);
                else if (d) begin
                    if (md == 0) go_load(0);
                    else if (md == 1) begin
                        if (m_track == NUM_SONGS - 1) go_load(0);
                        else start_next_song(m_track + 1);
                    end
                    else if (md == 2) start_next_song(next_track(m_track));
                    else start_next_song(m_track);
                end
                else if (n) begin m_track = next_track(m_track); go_load(1); end
                else if (v) begin m_track = prev_track(m_track); go_load(1); end
                else if (p) m_phase = PAUSED;
            end
            PAUSED: begin
                if (s) go_load(0);
                else if (n) begin m_track = next_track(m_track); go_load(0); end
                else if (v) begin m_track = prev_track(m_track); go_load(0); end
                else if (p) m_phase = PLAYING;
            end
            default: begin
                if (s) go_load(0);
                else begin
                    m_gap_left = m_gap_left - 1;
                    if (m_gap_left == 0) go_load(1);
                end
            end
        endcase
    endfunction

    task automatic cyc(input bit p, input bit s, input bit n, input bit v, input bit d);
        exp_t e;
        @(negedge clk);
        #2;
        play_button = p; stop_button = s; next_button = n; prev_button = v; song_done = d;
        mode = 2'(cur_mode);
        model_step(p, s, n, v, d, cur_mode);
        e.st = m_phase; e.sg = m_track; e.pl = (m_phase == PLAYING); e.rp = (m_phase == LOAD);
        q.push_back(e);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_now(input string name);
        checks++;
        if (state !== 3'd0 || song !== '0 || play !== 1'b0 || reset_player !== 1'b0) begin
            errors++;
            $display("FAIL %s: state=%0d song=%0d play=%0b reset_player=%0b, required 0/0/0/0",
                     name, state, song, play, reset_player);
        end
    endtask

    // Asynchronous assertion away from the clock edge; outputs must clear without a clock
    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        reset = 1'b1;
        play_button = 0; stop_button = 0; next_button = 0; prev_button = 0; song_done = 0;
        model_reset();
        #1;
        check_reset_now(name);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cycle_no++;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (state !== 3'(e.st) || song !== SONG_W'(e.sg) || play !== e.pl || reset_player !== e.rp) begin
                    errors++;
                    $display("FAIL cycle_%0d: got state=%0d song=%0d play=%0b reset_player=%0b, required state=%0d song=%0d play=%0b reset_player=%0b",
                             cycle_no, state, song, play, reset_player, e.st, e.sg, e.pl, e.rp);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit expired, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        model_reset();
        #3;
        check_reset_now("reset_at_start");
        #20;
        reset = 1'b0;

        // play from idle, then pause for ten cycles and resume
        cyc(1, 0, 0, 0, 0); idle(3);
        cyc(1, 0, 0, 0, 0); idle(10);
        cyc(1, 0, 0, 0, 0); idle(2);

        // sequential: skip to the last song, song_done stops playback
        cur_mode = 1;
        repeat (3) begin cyc(0, 0, 1, 0, 0); idle(2); end
        cyc(0, 0, 0, 0, 1); idle(3);
        cyc(0, 0, 0, 1, 0); idle(2);
        cyc(0, 0, 0, 1, 0); idle(2);
        cyc(1, 0, 0, 0, 0); idle(2);
        cyc(0, 0, 0, 0, 1); idle(12);

        // loop-all wraps from the last song to song 0 after the gap
        cur_mode = 2;
        cyc(0, 0, 1, 0, 0); idle(2);
        cyc(0, 0, 0, 0, 1); idle(12);

        // stop to idle, prev wraps, then stop beats next while playing
        cyc(0, 1, 0, 0, 0); idle(2);
        cyc(0, 0, 0, 1, 0); idle(2);
        cyc(1, 0, 0, 0, 0); idle(2);
        cyc(0, 1, 1, 0, 0); idle(3);

        // reset in the middle of a gap, then a clean gap on the next song
        cyc(1, 0, 0, 0, 0); idle(2);
        cyc(0, 0, 0, 0, 1); idle(4);
        do_reset("reset_mid_gap");
        cur_mode = 3;
        cyc(1, 0, 0, 0, 0); idle(2);
        cyc(0, 0, 0, 0, 1); idle(12);

        for (int i = 0; i < 2500; i++) begin
            int r;
            bit p, s, n, v, d;
            if (i % 600 == 599) do_reset("reset_random");
            if ($urandom_range(0, 49) == 0) cur_mode = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 99));
            p = (r < 12);
            s = ($urandom_range(0, 39) == 0);
            n = ($urandom_range(0, 14) == 0);
            v = ($urandom_range(0, 14) == 0);
            d = ($urandom_range(0, 9) == 0);
            cyc(p, s, n, v, d);
        end
        idle(1);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Playback controller in front of song_reader: turns debounced front-panel button pulses and song_reader's song_done into song_reader's play, song select and restart controls.
- Implements play/pause, stop, next/prev track, four playback modes and a silent inter-song gap.
- Sits between the button debouncers and song_reader.
- The only block that drives song_reader's play and song inputs.

Parameters:
- SONG_W, 2, width of song index.
- NUM_SONGS, 4, number of songs; indices 0..NUM_SONGS-1; must be ≤ 2**SONG_W.
- GAP_CYCLES, 8, silent cycles between consecutive songs (0 = no gap); must be < 65536.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play_button  in  1  one-cycle pulse: play / pause toggle
- stop_button  in  1  one-cycle pulse: stop and rewind current song
- next_button  in  1  one-cycle pulse: next song
- prev_button  in  1  one-cycle pulse: previous song
- mode  in  2  00 single, 01 sequential, 10 loop-all, 11 repeat-one
- song_done  in  1  from song_reader: current song finished
- play  out  1  to song_reader play
- reset_player  out  1  to song_reader reset; one-cycle restart pulse
- song  out  SONG_W  to song_reader song select
- state  out  3  status: 0 IDLE, 1 LOAD, 2 PLAYING, 3 PAUSED, 4 GAP

Behaviour:
- Registers:
  - state register
  - song index register
  - resume flag (target after LOAD)
  - 16-bit gap counter
- Reset (async): state=IDLE, song=0, resume=0, counter=0. Consequently play=0 and reset_player=0 while reset is asserted and after release.
- Outputs are Moore decodes of the state register:
  - play=1 only in PLAYING.
  - reset_player=1 only in LOAD.
  - song = song register.
- Input sampled at edge k → new state visible after edge k. No further latency.
- Wrap arithmetic:
  - inc: song==NUM_SONGS-1 → 0, else +1.
  - dec: song==0 → NUM_SONGS-1, else -1.
- Per-cycle event priority: stop > song_done > next > prev > play_button. Only the highest event acts; the rest are dropped.
- IDLE:
  - play_button → LOAD, resume=1.
  - next/prev → song inc/dec, LOAD, resume=0.
  - stop → LOAD, resume=0.
  - song_done is ignored.
- LOAD:
  - Lasts exactly one cycle; all inputs are ignored.
  - Then → PLAYING if resume=1, else IDLE.
- PLAYING:
  - stop → LOAD, resume=0, song unchanged.
  - song_done (mode sampled this cycle):
    - single: → LOAD, resume=0.
    - sequential, song<NUM_SONGS-1: song+1, → GAP.
    - sequential, last song: → LOAD, resume=0, song unchanged.
    - loop-all: song inc (wrap), → GAP.
    - repeat-one: song unchanged, → GAP.
  - next/prev → song inc/dec, LOAD, resume=1. No gap.
  - play_button → PAUSED.
- PAUSED:
  - play_button → PLAYING. No reset_player; song_reader continues the interrupted note.
  - stop → LOAD, resume=0.
  - next/prev → song inc/dec, LOAD, resume=0 (ends stopped).
  - song_done is ignored.
- GAP:
  - On entry, counter loads GAP_CYCLES-1; it decrements each cycle.
  - counter==0 → LOAD, resume=1.
  - GAP therefore lasts exactly GAP_CYCLES cycles.
  - If GAP_CYCLES==0, the song_done transition goes directly to LOAD, resume=1 and GAP is never entered.
  - stop → LOAD, resume=0 (aborts gap).
  - All other buttons and song_done are ignored.
- mode is only sampled on song_done; changing it mid-song has no other effect.
- Reset asserted mid-operation returns to IDLE/song 0 immediately, independent of clk.
- Illegal state encodings (5-7) → IDLE on the next edge.

Test Plan:
- Reset released, play_button pulse:
  - state 0→1 for one cycle with reset_player=1.
  - Then state=2, play=1, song=0.
- Play song 0, pulse play_button, wait 10 cycles, pulse play_button:
  - play low for exactly the paused span.
  - No reset_player pulse; state 2→3→2.
- mode=01, GAP_CYCLES=8, song=3 (last), song_done pulse:
  - → LOAD then IDLE, song stays 3, play=0.
- Same setup with song=1:
  - song=2, play=0 for exactly 8 cycles.
  - One reset_player cycle, then play=1.
- mode=10 at song 3, song_done → song=0 after gap, playing.
- IDLE at song 0:
  - prev_button → song=3 (wrap) with one reset_player cycle.
  - Simultaneous stop+next while PLAYING → stop wins, song unchanged, state ends IDLE.
- Assert reset during GAP mid-count:
  - Immediately play=0, reset_player=0, state=0, song=0.
  - Counter restarts cleanly on the next song.
